// File: rtl/code_loader_pkg.sv
// Shared types and sizes for the program loader that fills the 64x16 instruction store.
package code_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    WRITE   = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5,
    FAIL    = 3'd6
  } loader_state_t;

  localparam int INSTR_DEPTH = 64;
  localparam int INSTR_W     = 16;
  localparam int BYTE_W      = 8;

endpackage

// File: rtl/code_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words, writes them from address 0,
// then verifies a trailing mod-256 checksum while holding the CPU stalled.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = INSTR_W,
  parameter int DEPTH  = INSTR_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [6:0]        word_count,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_write_select,
  output logic [DATA_W-1:0] mem_inp,
  output logic              mem_write_en,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [6:0] MAX_COUNT = 7'(DEPTH);

  loader_state_t     r_state;
  loader_state_t     w_nextState;
  logic [ADDR_W-1:0] r_addr;
  logic [6:0]        r_count;
  logic [DATA_W-1:0] r_word;
  logic [BYTE_W-1:0] r_acc;
  logic              r_done;
  logic              r_error;

  logic w_idleLike;
  logic w_startOk;
  logic w_tooMany;
  logic w_accept;
  logic w_lastWord;

  assign w_idleLike = (r_state == IDLE) || (r_state == DONE) || (r_state == FAIL);
  assign w_startOk  = start && w_idleLike;
  assign w_tooMany  = word_count > MAX_COUNT;
  assign w_accept   = byte_valid && byte_ready;
  assign w_lastWord = (7'({1'b0, r_addr}) + 7'd1) == r_count;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE, DONE, FAIL: begin
        if (w_startOk) begin
          if (w_tooMany)              w_nextState = FAIL;
          else if (word_count == '0)  w_nextState = CHECK;
          else                        w_nextState = LOAD_HI;
        end
      end
      LOAD_HI: if (byte_valid) w_nextState = LOAD_LO;
      LOAD_LO: if (byte_valid) w_nextState = WRITE;
      WRITE:   w_nextState = w_lastWord ? CHECK : LOAD_HI;
      CHECK: begin
        if (byte_valid) w_nextState = (byte_in == r_acc) ? DONE : FAIL;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Everything here decodes registered state only, so byte_ready never depends on byte_valid.
  always_comb begin
    byte_ready   = 1'b0;
    mem_write_en = 1'b0;
    busy         = 1'b0;
    cpu_hold     = 1'b1;
    unique case (r_state)
      IDLE, DONE:              cpu_hold = 1'b0;
      LOAD_HI, LOAD_LO, CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        busy         = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_write_select = r_addr;
  assign mem_inp          = r_word;
  assign done             = r_done;
  assign error            = r_error;

  // The address holds on the final write so a full 64-word load never wraps back to 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= '0;
      r_count <= '0;
      r_word  <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE, FAIL: begin
          if (w_startOk) begin
            if (w_tooMany) begin
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_done  <= 1'b0;
              r_error <= 1'b0;
              r_addr  <= '0;
              r_acc   <= '0;
              r_count <= word_count;
            end
          end
        end
        LOAD_HI: begin
          if (w_accept) begin
            r_word[DATA_W-1 -: BYTE_W] <= byte_in;
            r_acc                      <= r_acc + byte_in;
          end
        end
        LOAD_LO: begin
          if (w_accept) begin
            r_word[BYTE_W-1:0] <= byte_in;
            r_acc              <= r_acc + byte_in;
          end
        end
        WRITE: begin
          if (!w_lastWord) r_addr <= r_addr + 1'b1;
        end
        CHECK: begin
          if (w_accept) begin
            r_done  <= 1'b1;
            r_error <= (byte_in != r_acc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader: expected store writes are queued as bytes are sent
// and checked against each write strobe; flags and timing are asserted step by step.
module tb_code_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [5:0]  mem_write_select;
  logic [15:0] mem_inp;
  logic        mem_write_en;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  code_loader dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .word_count       (word_count),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .mem_write_select (mem_write_select),
    .mem_inp          (mem_inp),
    .mem_write_en     (mem_write_en),
    .cpu_hold         (cpu_hold),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t        expQ[$];
  int         tests = 0;
  int         fails = 0;
  int         cycle = 0;
  int         writes = 0;
  int         lastWrAddr = -1;
  int         t0;
  logic [5:0] expAddr = '0;
  logic [7:0] sum = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; samples 1 ns after the edge and scores any store write against the queue.
  task automatic tick();
    wr_t e;
    @(posedge clock);
    #1;
    cycle++;
    if (mem_write_en === 1'b1) begin
      checkOutput("write_expected", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("write_addr", 32'(mem_write_select), 32'(e.addr));
        checkOutput("write_data", 32'(mem_inp), 32'(e.data));
        writes++;
        lastWrAddr = int'(mem_write_select);
      end
    end
  endtask

  // Offers one byte until accepted; byte_valid is asserted with probability prob percent.
  task automatic applyStimulus(input logic [7:0] b, input int prob);
    bit got = 1'b0;
    byte_in = b;
    for (int i = 0; i < 1000 && !got; i++) begin
      byte_valid = ($urandom_range(99) < prob);
      if (byte_valid && (byte_ready === 1'b1)) got = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    if (!got) checkOutput("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic pushWord(input logic [15:0] w, input int prob);
    expQ.push_back({expAddr, w});
    expAddr = expAddr + 6'd1;
    sum = sum + w[15:8] + w[7:0];
    applyStimulus(w[15:8], prob);
    applyStimulus(w[7:0], prob);
  endtask

  task automatic startLoad(input logic [6:0] n);
    start      = 1'b1;
    word_count = n;
    expAddr    = '0;
    sum        = '0;
    writes     = 0;
    lastWrAddr = -1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    word_count = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    tick();
    tick();
    checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst_write_en", 32'(mem_write_en), 32'd0);
    checkOutput("rst_select", 32'(mem_write_select), 32'd0);
    checkOutput("rst_inp", 32'(mem_inp), 32'd0);
    checkOutput("rst_hold", 32'(cpu_hold), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    tick();

    // Two-word load, byte_valid always high, good checksum.
    startLoad(7'd2);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_hold", 32'(cpu_hold), 32'd1);
    checkOutput("t1_ready", 32'(byte_ready), 32'd1);
    t0 = cycle;
    pushWord(16'h3000, 100);
    pushWord(16'h8C09, 100);
    applyStimulus(8'hC5, 100);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_error", 32'(error), 32'd0);
    checkOutput("t1_hold_low", 32'(cpu_hold), 32'd0);
    checkOutput("t1_cycles", 32'(cycle - t0), 32'd7);
    checkOutput("t1_writes", 32'(writes), 32'd2);
    checkOutput("t1_queue_empty", 32'(expQ.size()), 32'd0);

    // Same load with a bad checksum, then recovery with good data.
    startLoad(7'd2);
    pushWord(16'h3000, 100);
    pushWord(16'h8C09, 100);
    applyStimulus(8'hC4, 100);
    checkOutput("t2_done", 32'(done), 32'd1);
    checkOutput("t2_error", 32'(error), 32'd1);
    checkOutput("t2_hold", 32'(cpu_hold), 32'd1);
    checkOutput("t2_writes", 32'(writes), 32'd2);
    tick();
    tick();
    checkOutput("t2_hold_stays", 32'(cpu_hold), 32'd1);
    startLoad(7'd2);
    checkOutput("t2_done_cleared", 32'(done), 32'd0);
    checkOutput("t2_error_cleared", 32'(error), 32'd0);
    pushWord(16'h3000, 100);
    pushWord(16'h8C09, 100);
    applyStimulus(8'hC5, 100);
    checkOutput("t2_rec_done", 32'(done), 32'd1);
    checkOutput("t2_rec_error", 32'(error), 32'd0);
    checkOutput("t2_rec_hold", 32'(cpu_hold), 32'd0);

    // Oversized count goes straight to the fault state.
    startLoad(7'd65);
    checkOutput("t3_done", 32'(done), 32'd1);
    checkOutput("t3_error", 32'(error), 32'd1);
    checkOutput("t3_ready", 32'(byte_ready), 32'd0);
    checkOutput("t3_busy", 32'(busy), 32'd0);
    checkOutput("t3_hold", 32'(cpu_hold), 32'd1);
    tick();
    tick();
    tick();
    checkOutput("t3_ready_later", 32'(byte_ready), 32'd0);
    checkOutput("t3_writes", 32'(writes), 32'd0);

    // Full 64-word load with random data.
    startLoad(7'd64);
    for (int i = 0; i < 64; i++) pushWord(16'($urandom), 100);
    applyStimulus(sum, 100);
    checkOutput("t4_done", 32'(done), 32'd1);
    checkOutput("t4_error", 32'(error), 32'd0);
    checkOutput("t4_writes", 32'(writes), 32'd64);
    checkOutput("t4_last_addr", 32'(lastWrAddr), 32'd63);
    checkOutput("t4_queue_empty", 32'(expQ.size()), 32'd0);

    // Random byte_valid gaps and a start pulse while busy.
    startLoad(7'd4);
    pushWord(16'($urandom), 50);
    start      = 1'b1;
    word_count = 7'd1;
    tick();
    start = 1'b0;
    checkOutput("t5_still_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) pushWord(16'($urandom), 50);
    applyStimulus(sum, 50);
    checkOutput("t5_done", 32'(done), 32'd1);
    checkOutput("t5_error", 32'(error), 32'd0);
    checkOutput("t5_writes", 32'(writes), 32'd4);
    checkOutput("t5_queue_empty", 32'(expQ.size()), 32'd0);

    // Reset while the first write strobe is active.
    startLoad(7'd2);
    pushWord(16'hBEEF, 100);
    checkOutput("t6_in_write", 32'(mem_write_en), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("t6_write_en", 32'(mem_write_en), 32'd0);
    checkOutput("t6_select", 32'(mem_write_select), 32'd0);
    checkOutput("t6_inp", 32'(mem_inp), 32'd0);
    checkOutput("t6_hold", 32'(cpu_hold), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_done", 32'(done), 32'd0);
    checkOutput("t6_error", 32'(error), 32'd0);
    checkOutput("t6_queue_empty", 32'(expQ.size()), 32'd0);
    tick();

    // Zero-word load expects only a 0x00 checksum.
    startLoad(7'd0);
    checkOutput("t7_ready", 32'(byte_ready), 32'd1);
    checkOutput("t7_busy", 32'(busy), 32'd1);
    applyStimulus(8'h00, 100);
    checkOutput("t7_done", 32'(done), 32'd1);
    checkOutput("t7_error", 32'(error), 32'd0);
    checkOutput("t7_hold", 32'(cpu_hold), 32'd0);
    checkOutput("t7_writes", 32'(writes), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/code_loader.md
# code_loader

Program loader that sits directly upstream of the 64×16 instruction store and fills it from an external byte stream before the CPU runs. It accepts bytes over a valid/ready handshake and assembles them high-byte-first into 16-bit instruction words. It drives the instruction store's write port at consecutive addresses from 0, then checks a trailing 8-bit checksum. While loading, and after a failed load, it holds the CPU core stalled.

## Interface
- `ADDR_W`, 6: instruction store address width.
- `DATA_W`, 16: instruction width; fixed at two bytes.
- `DEPTH`, 64: number of instruction words.
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle load request; honoured only in IDLE, DONE or FAIL.
- `word_count`  in  7: number of words to load, 0..64; sampled on an accepted `start`.
- `byte_in`  in  8: stream data.
- `byte_valid`  in  1: `byte_in` is valid.
- `byte_ready`  out  1: loader accepts a byte this cycle.
- `mem_write_select`  out  ADDR_W: instruction store write address.
- `mem_inp`  out  DATA_W: instruction store write data.
- `mem_write_en`  out  1: instruction store write strobe.
- `cpu_hold`  out  1: stall or hold the CPU core.
- `busy`  out  1: a load is in progress.
- `done`  out  1: the last load has finished, pass or fail.
- `error`  out  1: the last load failed.

## Operation
- States:
  - IDLE → LOAD_HI → LOAD_LO → WRITE → (LOAD_HI | CHECK) → DONE or FAIL.
  - DONE and FAIL behave like IDLE, except that their flags remain set.
- Accepted `start` with `word_count` = 0:
  - go to CHECK, expecting a checksum of 0x00.
  - no memory writes.
- Accepted `start` with `word_count` > 64:
  - go directly to FAIL: `error`=1, `done`=1, no bytes consumed, no writes.
- Accepted `start` with a valid count:
  - clear `done`, `error`, the address counter, and the 8-bit checksum accumulator.
  - latch the count.
- LOAD_HI / LOAD_LO:
  - `byte_ready`=1.
  - A transfer occurs when `byte_valid` and `byte_ready` are both high.
  - The HI byte goes to bits [15:8] and the LO byte to [7:0].
  - Each accepted byte is added to the accumulator modulo 256.
- WRITE:
  - `byte_ready`=0.
  - `mem_write_en`=1 for exactly one cycle, with `mem_write_select` = current address and `mem_inp` = the assembled word.
  - On the next edge, the address increments.
  - Go to CHECK if this was word `count`-1, otherwise go to LOAD_HI.
- CHECK:
  - `byte_ready`=1.
  - An accepted byte equal to the accumulator → DONE with `error`=0.
  - Any other value → FAIL with `error`=1.
  - `done`=1 in both cases.
- `cpu_hold`=1 in every state except IDLE and DONE. It stays high in FAIL until the next successful load or `reset`.
- `busy`=1 in LOAD_HI, LOAD_LO, WRITE and CHECK.
- `start` while busy is ignored.
- Address never wraps: a 64-word load ends with its last write at address 63.

## Timing
- Reset (synchronous, active-high) values:
  - state IDLE; counters 0.
  - `byte_ready`=0, `mem_write_en`=0, `mem_write_select`=0, `mem_inp`=0.
  - `cpu_hold`=0, `busy`=0, `done`=0, `error`=0.
- Reset asserted mid-load aborts the load immediately. The instruction store keeps any words already written.
- `start` accepted at edge N → `busy`=1, `cpu_hold`=1 and `byte_ready`=1 during cycle N+1.
- The LO byte accepted at edge M → `mem_write_en` high during cycle M+1 only.
- Best-case cost with `byte_valid` held high:
  - 3 cycles per word.
  - plus 1 cycle for the checksum byte.
  - `done` rises one cycle after the checksum is accepted.
- `byte_valid` low stalls the loader indefinitely in the current LOAD or CHECK state, with no timeout.
- All outputs are registered or decoded from registered state only. There is no combinational path from `byte_valid` to `byte_ready`.

## Structure
- Shared package `code_loader_pkg` holds:
  - state encoding (3-bit `loader_state_t`: IDLE, LOAD_HI, LOAD_LO, WRITE, CHECK, DONE, FAIL).
  - `INSTR_DEPTH`=64 and `INSTR_W`=16.
  - `BYTE_W`=8.
- Single module; no sub-module. The checksum accumulator and word assembler are small enough to live inline.
- Top level connects `mem_write_select`, `mem_inp` and `mem_write_en` straight to the instruction store's write port.

## Test plan
- 2-word load with `byte_valid` always high:
  - stimulus: bytes 0x30,0x00,0x8C,0x09, then checksum 0xC5.
  - response: writes 0x3000@0 and 0x8C09@1; `done`=1, `error`=0, `cpu_hold` falls.
  - total 7 cycles from first `byte_ready` to `done`.
- Same load with checksum 0xC4:
  - response: both writes still occur; FAIL with `done`=1, `error`=1, `cpu_hold` stays 1.
  - a new `start` with good data clears the fault.
- `word_count`=65:
  - response: next cycle `done`=1, `error`=1; no `byte_ready`, no writes.
- `word_count`=64 with random bytes and a correct checksum:
  - response: 64 strobes at addresses 0..63 in order, no wrap; final word correct.
- `byte_valid` toggled randomly, plus `start` pulsed mid-load:
  - response: the word sequence is unchanged and the mid-load `start` is ignored.
- `reset` asserted during WRITE:
  - response: next cycle all outputs are at their reset values and state is IDLE.
- `word_count`=0 followed by checksum 0x00:
  - response: DONE with no writes.
